clock_period_meter: RTL and testbench

Measures the signal produced by the CPU clock generator, `clock_main`, from inside the 50 MHz domain. It synchronises the incoming clock, detects its edges and counts `clock_50MHz` cycles per full period and per high phase. Each completed period produces one result with a one-cycle `valid` strobe. If the input stops toggling, the block raises `stopped`. Its consumers are the front-panel display logic and the simulation self-checks, which use it to confirm fast mode, slow mode and enable/halt behaviour.

---
 rtl/clock_meter_pkg.sv | 18 +
 rtl/sync_edge_detect.sv | 29 ++
 rtl/clock_period_meter.sv | 105 ++++++++++
 tb/tb_clock_period_meter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_meter_pkg.sv
// Shared types and constants for the clock period meter and its benches.
package clock_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        STOPPED
    } meter_state_t;

    localparam int METER_CNT_W   = 32;
    localparam int METER_TIMEOUT = 60_000_000;

    // Half-periods of the CPU clock generator in fast and slow mode.
    localparam int FAST_HALF = 26;
    localparam int SLOW_HALF = 25_000_001;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus history flop for an asynchronous level input.
// Produces single-cycle rise/fall pulses in the local clock domain.
module sync_edge_detect (
    input  logic clock_50MHz,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // s1/s2 resolve metastability, s3 keeps the previous settled level.
    always_ff @(posedge clock_50MHz) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high phase of an asynchronous clock in clock_50MHz
// cycles; flags a stopped input after TIMEOUT cycles without a rising edge.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W   = METER_CNT_W,
    parameter int TIMEOUT = METER_TIMEOUT
) (
    input  logic             clock_50MHz,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stopped
);

    // Last count value reachable; reaching it without a rise is a timeout.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic             rise, fall;
    meter_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr, cnt_inc, ld_period, ld_high;

    sync_edge_detect u_sync (
        .clock_50MHz (clock_50MHz),
        .rst         (rst),
        .d           (clk_in),
        .rise        (rise),
        .fall        (fall)
    );

    // State register.
    always_ff @(posedge clock_50MHz) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and datapath controls. Disable beats edges; a rise beats
    // the timeout, so a rise landing on the last count is a normal period.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        ld_period = 1'b0;
        ld_high   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                    cnt_clr   = 1'b1;
                end
                ARM: begin
                    if (rise) begin
                        cnt_clr   = 1'b1;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    ld_high = fall;
                    if (rise) begin
                        ld_period = 1'b1;
                        cnt_clr   = 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = STOPPED;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                STOPPED: begin
                    // Recovery edge only restarts the count; no result.
                    if (rise) begin
                        cnt_clr   = 1'b1;
                        state_nxt = MEASURE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Cycle counter, result registers and valid strobe.
    always_ff @(posedge clock_50MHz) begin
        if (rst) begin
            cnt       <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= ld_period;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + CNT_W'(1);
            if (ld_period) period    <= cnt + CNT_W'(1);
            if (ld_high)   high_time <= cnt + CNT_W'(1);
        end
    end

    assign stopped = (state == STOPPED);

endmodule

// File: tb/tb_clock_period_meter.sv
module tb_clock_period_meter;
    import clock_meter_pkg::*;

    localparam int CNT_W = 32;
    localparam int TO    = 100;

    logic             clock_50MHz = 1'b0;
    logic             rst         = 1'b1;
    logic             clk_in      = 1'b0;
    logic             en          = 1'b0;
    logic [CNT_W-1:0] period, high_time;
    logic             valid, stopped;

    typedef struct {
        int unsigned per;
        int unsigned hi;
    } exp_t;

    exp_t sb[$];
    int   vcyc[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clock_50MHz (clock_50MHz),
        .rst         (rst),
        .clk_in      (clk_in),
        .en          (en),
        .period      (period),
        .high_time   (high_time),
        .valid       (valid),
        .stopped     (stopped)
    );

    always #10 clock_50MHz = ~clock_50MHz;

    always @(posedge clock_50MHz) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest pending expectation.
    always @(negedge clock_50MHz) begin : mon
        exp_t e;
        if (valid === 1'b1) begin
            vcyc.push_back(cyc);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: valid=1 at cycle %0d, required 0 (nothing pending)", cyc);
            end else begin
                e = sb.pop_front();
                if (period !== e.per) begin
                    n_err++;
                    $display("FAIL sb_period: got %0d, required %0d (cycle %0d)", period, e.per, cyc);
                end
                n_cmp++;
                if (high_time !== e.hi) begin
                    n_err++;
                    $display("FAIL sb_high_time: got %0d, required %0d (cycle %0d)", high_time, e.hi, cyc);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock_50MHz);
    endtask

    // Drive n periods of hi/lo; rises with index >= first_push complete a
    // measured period and queue the expected result.
    task automatic wave(input int hi, input int lo, input int n, input int first_push);
        for (int i = 0; i < n; i++) begin
            if (i >= first_push && i > 0) sb.push_back('{per: hi + lo, hi: hi});
            clk_in = 1'b1;
            tick(hi);
            clk_in = 1'b0;
            tick(lo);
        end
    endtask

    task automatic restart();
        en     = 1'b0;
        clk_in = 1'b0;
        tick(4);
        en = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_cmp++; if (period !== '0)     begin n_err++; $display("FAIL reset_period: got %0d, required 0", period); end
        n_cmp++; if (high_time !== '0)  begin n_err++; $display("FAIL reset_high_time: got %0d, required 0", high_time); end
        n_cmp++; if (valid !== 1'b0)    begin n_err++; $display("FAIL reset_valid: got %b, required 0", valid); end
        n_cmp++; if (stopped !== 1'b0)  begin n_err++; $display("FAIL reset_stopped: got %b, required 0", stopped); end
        n_cmp++; if (dut.state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required IDLE", dut.state); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_fast();
        restart();
        vcyc.delete();
        wave(FAST_HALF, FAST_HALF, 5, 0);
        n_cmp++;
        if (vcyc.size() != 4) begin
            n_err++; $display("FAIL fast_strobe_count: got %0d, required 4", vcyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (vcyc[i] - vcyc[i-1] != 2 * FAST_HALF) begin
                    n_err++; $display("FAIL fast_spacing: got %0d, required %0d", vcyc[i] - vcyc[i-1], 2 * FAST_HALF);
                end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL fast_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_asym();
        restart();
        wave(10, 30, 4, 0);
        n_cmp++; if (period !== 40)    begin n_err++; $display("FAIL asym_period: got %0d, required 40", period); end
        n_cmp++; if (high_time !== 10) begin n_err++; $display("FAIL asym_high_time: got %0d, required 10", high_time); end
        n_cmp++; if (sb.size() != 0)   begin n_err++; $display("FAIL asym_pending: got %0d, required 0", sb.size()); end
    endtask

    // Period equal to TIMEOUT completes normally; one cycle longer times out.
    task automatic test_boundary();
        restart();
        wave(50, 50, 3, 0);
        n_cmp++; if (stopped !== 1'b0) begin n_err++; $display("FAIL bound_stopped: got %b, required 0", stopped); end
        n_cmp++; if (sb.size() != 0)   begin n_err++; $display("FAIL bound_pending: got %0d, required 0", sb.size()); end
        restart();
        wave(51, 50, 3, 3);
        n_cmp++; if (period !== TO)    begin n_err++; $display("FAIL over_period_held: got %0d, required %0d", period, TO); end
    endtask

    task automatic test_timeout();
        int last, r;
        restart();
        wave(FAST_HALF, FAST_HALF, 2, 0);
        sb.push_back('{per: 52, hi: 26});
        last   = cyc;
        clk_in = 1'b1;
        tick(26);
        clk_in = 1'b0;
        tick(76);
        n_cmp++; if (stopped !== 1'b0) begin n_err++; $display("FAIL to_early: stopped=%b at +%0d, required 0", stopped, cyc - last); end
        tick();
        n_cmp++; if (stopped !== 1'b1) begin n_err++; $display("FAIL to_set: stopped=%b at +%0d, required 1", stopped, cyc - last); end
        tick(20);
        r      = cyc;
        clk_in = 1'b1;
        tick(2);
        n_cmp++; if (stopped !== 1'b1) begin n_err++; $display("FAIL to_hold: stopped=%b at +%0d, required 1", stopped, cyc - r); end
        tick();
        n_cmp++; if (stopped !== 1'b0) begin n_err++; $display("FAIL to_clear: stopped=%b at +%0d, required 0", stopped, cyc - r); end
        n_cmp++; if (valid !== 1'b0)   begin n_err++; $display("FAIL to_recover_valid: got %b, required 0", valid); end
        tick(23);
        clk_in = 1'b0;
        tick(26);
        sb.push_back('{per: 52, hi: 26});
        clk_in = 1'b1;
        tick(26);
        clk_in = 1'b0;
        tick(5);
        n_cmp++; if (period !== 52)  begin n_err++; $display("FAIL to_next_period: got %0d, required 52", period); end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL to_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_disable();
        restart();
        wave(FAST_HALF, FAST_HALF, 2, 0);
        sb.push_back('{per: 52, hi: 26});
        clk_in = 1'b1;
        tick(20);
        en = 1'b0;
        tick(6);
        clk_in = 1'b0;
        tick(26);
        clk_in = 1'b1;
        tick(26);
        clk_in = 1'b0;
        tick(4);
        n_cmp++; if (period !== 52)      begin n_err++; $display("FAIL dis_period: got %0d, required 52", period); end
        n_cmp++; if (dut.state !== IDLE) begin n_err++; $display("FAIL dis_state: got %0d, required IDLE", dut.state); end
        n_cmp++; if (stopped !== 1'b0)   begin n_err++; $display("FAIL dis_stopped: got %b, required 0", stopped); end
        en = 1'b1;
        tick(2);
        wave(FAST_HALF, FAST_HALF, 3, 0);
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL dis_pending: got %0d, required 0", sb.size()); end
    endtask

    task automatic test_reset_prio();
        restart();
        wave(FAST_HALF, FAST_HALF, 2, 0);
        clk_in = 1'b1;
        tick(2);
        rst = 1'b1;
        tick();
        n_cmp++; if (period !== '0)    begin n_err++; $display("FAIL rp_rise_period: got %0d, required 0", period); end
        n_cmp++; if (high_time !== '0) begin n_err++; $display("FAIL rp_rise_high_time: got %0d, required 0", high_time); end
        n_cmp++; if (valid !== 1'b0)   begin n_err++; $display("FAIL rp_rise_valid: got %b, required 0", valid); end
        rst = 1'b0;
        tick(24);
        clk_in = 1'b0;
        tick(10);
        restart();
        wave(FAST_HALF, FAST_HALF, 2, 0);
        tick(110);
        n_cmp++; if (stopped !== 1'b1) begin n_err++; $display("FAIL rp_pre_stopped: got %b, required 1", stopped); end
        rst = 1'b1;
        tick(2);
        n_cmp++; if (stopped !== 1'b0) begin n_err++; $display("FAIL rp_stop_stopped: got %b, required 0", stopped); end
        n_cmp++; if (period !== '0)    begin n_err++; $display("FAIL rp_stop_period: got %0d, required 0", period); end
        n_cmp++; if (valid !== 1'b0)   begin n_err++; $display("FAIL rp_stop_valid: got %b, required 0", valid); end
        rst = 1'b0;
        tick(3);
        n_cmp++; if (dut.state !== ARM) begin n_err++; $display("FAIL rp_rearm_state: got %0d, required ARM", dut.state); end
        n_cmp++; if (sb.size() != 0)    begin n_err++; $display("FAIL rp_pending: got %0d, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_fast();
        test_asym();
        test_boundary();
        test_timeout();
        test_disable();
        test_reset_prio();
        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
